// File: rtl/ahb_apb_bridge_mslave.sv
// AHB-Lite slave to APB3 master bridge with NUM_SLV decoded APB slaves.
// Adds PREADY wait states, PSLVERR/unmapped/timeout errors as two-cycle AHB ERROR responses.
module ahb_apb_bridge_mslave #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 3,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                      Hclk,
    input  logic                      Hresetn,
    input  logic                      Hsel,
    input  logic                      Hwrite,
    input  logic                      Hreadyin,
    input  logic [1:0]                Htrans,
    input  logic [ADDR_W-1:0]         Haddr,
    input  logic [DATA_W-1:0]         HWdata,
    output logic                      Hreadyout,
    output logic [1:0]                Hresp,
    output logic [DATA_W-1:0]         HRdata,
    output logic [NUM_SLV-1:0]        Pselx,
    output logic                      Penable,
    output logic                      Pwrite,
    output logic [ADDR_W-1:0]         Paddr,
    output logic [DATA_W-1:0]         PWdata,
    input  logic [NUM_SLV*DATA_W-1:0] PRdata,
    input  logic [NUM_SLV-1:0]        Pready,
    input  logic [NUM_SLV-1:0]        Pslverr
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_idx;
    logic [TW-1:0]       r_timer;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_pwrite;

    logic                w_valid;
    logic [3:0]          w_addr_idx;
    logic                w_sel_ready;
    logic                w_sel_err;
    logic [DATA_W-1:0]   w_sel_rdata;
    logic [NUM_SLV-1:0]  w_psel;
    logic                w_done;
    logic                w_tmo;
    logic                w_accept;
    logic                w_unused_ok;

    assign w_valid     = Hsel & Hreadyin & Htrans[1];
    assign w_addr_idx  = Haddr[SEL_LSB+3:SEL_LSB];
    assign w_unused_ok = Htrans[0];

    // Per-slave mux; an out-of-range index never reaches SETUP/ACCESS so it selects nothing.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        w_psel      = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_idx == 4'(i)) begin
                w_sel_ready = Pready[i];
                w_sel_err   = Pslverr[i];
                w_sel_rdata = PRdata[i*DATA_W +: DATA_W];
                w_psel[i]   = 1'b1;
            end
        end
    end

    assign w_done   = (r_state == S_ACCESS) & w_sel_ready & ~w_sel_err;
    assign w_tmo    = (TIMEOUT != 0) && (r_timer == TMO_LAST);
    assign w_accept = w_valid & ((r_state == S_IDLE) | w_done);

    assign Hreadyout = (r_state == S_IDLE) | (r_state == S_ERR2) | w_done;
    assign Hresp     = ((r_state == S_ERR1) | (r_state == S_ERR2)) ? 2'b01 : 2'b00;
    assign HRdata    = w_done ? w_sel_rdata : '0;
    assign Pselx     = ((r_state == S_SETUP) | (r_state == S_ACCESS)) ? w_psel : '0;
    assign Penable   = (r_state == S_ACCESS);
    assign Pwrite    = r_pwrite;
    assign Paddr     = r_paddr;
    assign PWdata    = r_pwdata;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_timer  <= '0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
        end else if (w_accept) begin
            r_paddr  <= Haddr;
            r_pwrite <= Hwrite;
            r_idx    <= w_addr_idx;
            r_timer  <= '0;
            if ({1'b0, w_addr_idx} >= 5'(NUM_SLV))
                r_state <= S_ERR1;
            else if (Hwrite)
                r_state <= S_WDATA;
            else
                r_state <= S_SETUP;
        end else begin
            case (r_state)
                S_WDATA: begin
                    r_pwdata <= HWdata;
                    r_timer  <= '0;
                    r_state  <= S_SETUP;
                end
                S_SETUP:  r_state <= S_ACCESS;
                S_ACCESS: begin
                    if (r_timer != TMO_MAX)
                        r_timer <= r_timer + 1'b1;
                    // A ready slave wins over a timeout landing in the same cycle.
                    if (w_sel_ready)
                        r_state <= w_sel_err ? S_ERR1 : S_IDLE;
                    else if (w_tmo)
                        r_state <= S_ERR1;
                end
                S_ERR1:  r_state <= S_ERR2;
                S_ERR2:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_apb_bridge_mslave.sv
// Randomized bench for ahb_apb_bridge_mslave: AHB driver, APB slave responders,
// reference model producing expected responses and a monitor that scores them.
module tb_ahb_apb_bridge_mslave;
    localparam int NS  = 3;
    localparam int TMO = 4;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        Hsel, Hwrite, Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr, HWdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] HRdata;
    logic [NS-1:0] Pselx;
    logic        Penable, Pwrite;
    logic [31:0] Paddr, PWdata;
    logic [NS*32-1:0] PRdata;
    logic [NS-1:0] Pready, Pslverr;

    assign Hreadyin = Hreadyout;

    ahb_apb_bridge_mslave #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(NS), .SEL_LSB(12), .TIMEOUT(TMO)
    ) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(Hsel), .Hwrite(Hwrite),
        .Hreadyin(Hreadyin), .Htrans(Htrans), .Haddr(Haddr), .HWdata(HWdata),
        .Hreadyout(Hreadyout), .Hresp(Hresp), .HRdata(HRdata),
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
        .PWdata(PWdata), .PRdata(PRdata), .Pready(Pready), .Pslverr(Pslverr)
    );

    always #5 Hclk = ~Hclk;

    int n_cmp = 0;
    int n_bad = 0;

    // expected AHB response: {latency[7:0], error, is_read, rdata[31:0]}
    logic [41:0] exp_q[$];
    // APB plan: {wdata[31:0], addr[31:0], write, slverr, wait_cycles[7:0]}
    logic [73:0] plan_q[$];

    logic [31:0] ref_mem [NS][16];
    logic [31:0] slv_mem [NS][16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        do begin
            @(negedge Hclk);
            n++;
        end while (!Hreadyout && n < 64);
        if (!Hreadyout) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: hreadyout still 0 after %0d cycles, required 1", nm, n);
        end
    endtask

    // Reference model: response derived from the transfer's decode and the slave's planned behaviour.
    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input int w, input bit err, input bit pipe);
        int idx, word, lat;
        bit mapped, ok;
        logic [31:0] rd_exp;
        idx    = int'(addr[15:12]);
        word   = int'(addr[5:2]);
        mapped = idx < NS;
        ok     = mapped && !err && (w < TMO);
        rd_exp = '0;
        if (!mapped)       lat = 2;
        else if (w >= TMO) lat = 7 + int'(wr);
        else if (err)      lat = w + 4 + int'(wr);
        else               lat = w + 2 + int'(wr);
        if (ok && !wr) rd_exp = ref_mem[idx][word];
        if (ok && wr)  ref_mem[idx][word] = data;
        exp_q.push_back({8'(lat), !ok, !wr, rd_exp});
        if (mapped) plan_q.push_back({data, addr, wr, err, 8'(w)});
        Hsel   = 1'b1;
        Htrans = 2'b10;
        Haddr  = addr;
        Hwrite = wr;
        wait_ready("addr_accept");
        @(posedge Hclk); #1;
        HWdata = data;
        if (pipe && ok) return;
        Htrans = 2'b00;
        Hsel   = 1'($urandom);
        Haddr  = $urandom;
        Hwrite = 1'($urandom);
        wait_ready("data_done");
        @(posedge Hclk); #1;
    endtask

    // Monitor: scores each data phase when the bridge finally drives Hreadyout high.
    initial begin : monitor
        bit dp = 0;
        bit saw_err1 = 0;
        int cyc = 0;
        logic [41:0] e;
        forever begin
            @(negedge Hclk);
            if (!Hresetn) begin
                dp = 0;
            end else begin
                if (dp) begin
                    cyc++;
                    if (!Hreadyout) begin
                        if (Hresp == 2'b01) begin
                            saw_err1 = 1;
                            chk("err1_pselx", 64'(Pselx), 64'd0);
                            chk("err1_penable", 64'(Penable), 64'd0);
                        end
                    end else begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_response: hresp=%0h with empty queue", Hresp);
                        end else begin
                            e = exp_q.pop_front();
                            chk("hresp", 64'(Hresp), e[33] ? 64'd1 : 64'd0);
                            chk("latency", 64'(cyc), 64'(e[41:34]));
                            if (e[33])
                                chk("err_two_cycle", 64'(saw_err1), 64'd1);
                            else if (e[32])
                                chk("hrdata", 64'(HRdata), 64'(e[31:0]));
                        end
                        dp = 0;
                    end
                end
                if (Hsel && Htrans[1] && Hreadyout) begin
                    dp = 1;
                    cyc = 0;
                    saw_err1 = 0;
                end
            end
        end
    end

    // APB slaves: respond from the plan queue, random noise on every unselected lane.
    initial begin : apb_slaves
        logic [73:0] cur;
        logic [31:0] c_wdata, c_addr;
        bit c_wr, c_err, active;
        int c_w, cnt, sidx, sword;
        active = 0;
        cnt = 0;
        c_w = 0; c_wr = 0; c_err = 0; sidx = 0; sword = 0;
        c_wdata = '0; c_addr = '0;
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < 16; k++) slv_mem[s][k] = '0;
        slv_mem[1][1] = 32'hDEAD_BEEF;
        PRdata = '0; Pready = '0; Pslverr = '0;
        forever begin
            @(posedge Hclk); #1;
            PRdata  = {$urandom, $urandom, $urandom};
            Pready  = 3'($urandom);
            Pslverr = 3'($urandom);
            if (!Hresetn) begin
                active = 0;
            end else if (Pselx != '0 && !Penable) begin
                if (plan_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_setup: pselx=%0b with no planned transfer", Pselx);
                end else begin
                    cur     = plan_q.pop_front();
                    c_wdata = cur[73:42];
                    c_addr  = cur[41:10];
                    c_wr    = cur[9];
                    c_err   = cur[8];
                    c_w     = int'(cur[7:0]);
                    sidx    = int'(c_addr[15:12]);
                    sword   = int'(c_addr[5:2]);
                    cnt     = 0;
                    active  = 1;
                end
            end else if (active && Penable) begin
                if (cnt == c_w) begin
                    Pready[sidx]  = 1'b1;
                    Pslverr[sidx] = c_err;
                    PRdata[sidx*32 +: 32] = slv_mem[sidx][sword];
                    chk("apb_paddr", 64'(Paddr), 64'(c_addr));
                    chk("apb_pwrite", 64'(Pwrite), 64'(c_wr));
                    chk("apb_pselx", 64'(Pselx), 64'(3'b001 << sidx));
                    if (c_wr) chk("apb_pwdata", 64'(PWdata), 64'(c_wdata));
                    if (c_wr && !c_err) slv_mem[sidx][sword] = c_wdata;
                    active = 0;
                end else begin
                    Pready[sidx] = 1'b0;
                    cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int idx, word, w;
        bit wr, err, pipe;
        logic [31:0] addr;
        Hresetn = 1'b0;
        Hsel = 1'b0; Htrans = 2'b00; Haddr = '0; Hwrite = 1'b0; HWdata = '0;
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < 16; k++) ref_mem[s][k] = '0;
        ref_mem[1][1] = 32'hDEAD_BEEF;

        repeat (3) @(negedge Hclk);
        chk("rst_hreadyout", 64'(Hreadyout), 64'd1);
        chk("rst_hresp", 64'(Hresp), 64'd0);
        chk("rst_hrdata", 64'(HRdata), 64'd0);
        chk("rst_pselx", 64'(Pselx), 64'd0);
        chk("rst_penable", 64'(Penable), 64'd0);
        chk("rst_pwrite", 64'(Pwrite), 64'd0);
        chk("rst_paddr", 64'(Paddr), 64'd0);
        chk("rst_pwdata", 64'(PWdata), 64'd0);
        Hresetn = 1'b1;
        @(posedge Hclk); #1;

        do_xfer(0, 32'h0000_1004, 32'h0,          0, 0, 0);
        do_xfer(1, 32'h0000_2010, 32'h1234_5678,  3, 0, 0);
        do_xfer(0, 32'h0000_0008, 32'h0,          0, 1, 0);
        do_xfer(0, 32'h0000_5000, 32'h0,          0, 0, 0);
        do_xfer(0, 32'h0000_1008, 32'h0,          5, 0, 0);
        do_xfer(0, 32'h0000_2010, 32'h0,          0, 0, 0);
        do_xfer(1, 32'h0000_0004, 32'hCAFE_F00D,  0, 0, 1);
        do_xfer(0, 32'h0000_0004, 32'h0,          1, 0, 0);
        do_xfer(1, 32'h0000_1000, 32'hA5A5_0001,  0, 1, 0);
        do_xfer(1, 32'h0000_F03C, 32'h0BAD_0BAD,  0, 0, 0);

        for (int t = 0; t < 80; t++) begin
            idx  = ($urandom_range(0, 4) < NS) ? int'($urandom_range(0, NS - 1))
                                               : int'($urandom_range(NS, 15));
            word = int'($urandom_range(0, 15));
            addr = (32'(idx) << 12) | (32'(word) << 2);
            wr   = 1'($urandom);
            w    = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3))
                                              : int'($urandom_range(TMO, TMO + 1));
            err  = ($urandom_range(0, 7) == 0);
            pipe = 1'($urandom);
            do_xfer(wr, addr, $urandom, w, err, pipe);
        end

        // Reset asserted while a read sits in ACCESS.
        plan_q.push_back({32'h0, 32'h0000_1000, 1'b0, 1'b0, 8'd50});
        Hsel = 1'b1; Htrans = 2'b10; Haddr = 32'h0000_1000; Hwrite = 1'b0;
        wait_ready("rst_accept");
        @(posedge Hclk); #1;
        Hsel = 1'b0; Htrans = 2'b00;
        begin
            int n = 0;
            do begin
                @(negedge Hclk);
                n++;
            end while (!Penable && n < 16);
            chk("rst_mid_reached_access", 64'(Penable), 64'd1);
        end
        #2;
        Hresetn = 1'b0;
        #1;
        chk("rst_mid_pselx", 64'(Pselx), 64'd0);
        chk("rst_mid_penable", 64'(Penable), 64'd0);
        chk("rst_mid_hreadyout", 64'(Hreadyout), 64'd1);
        chk("rst_mid_hresp", 64'(Hresp), 64'd0);
        chk("rst_mid_paddr", 64'(Paddr), 64'd0);
        repeat (2) @(negedge Hclk);
        plan_q.delete();
        Hresetn = 1'b1;
        @(posedge Hclk); #1;

        do_xfer(0, 32'h0000_2010, 32'h0, 0, 0, 0);
        do_xfer(0, 32'h0000_0004, 32'h0, 2, 0, 0);

        repeat (4) @(negedge Hclk);
        chk("drain_exp_q", 64'(exp_q.size()), 64'd0);
        chk("drain_plan_q", 64'(plan_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
